// File: rtl/dino_pkg.sv
// Shared definitions for the Gamepad PMOD button word: the bit position of each
// button and the word a disconnected controller reports.
package dino_pkg;

  localparam int unsigned BTN_W = 12;

  typedef logic [BTN_W-1:0] btn_word_t;

  localparam int unsigned BTN_B      = 11;
  localparam int unsigned BTN_Y      = 10;
  localparam int unsigned BTN_SELECT = 9;
  localparam int unsigned BTN_START  = 8;
  localparam int unsigned BTN_UP     = 7;
  localparam int unsigned BTN_DOWN   = 6;
  localparam int unsigned BTN_LEFT   = 5;
  localparam int unsigned BTN_RIGHT  = 4;
  localparam int unsigned BTN_A      = 3;
  localparam int unsigned BTN_X      = 2;
  localparam int unsigned BTN_L      = 1;
  localparam int unsigned BTN_R      = 0;

  // An unplugged controller pulls every button line high.
  localparam btn_word_t GAMEPAD_ABSENT_WORD = 12'hFFF;

endpackage

// File: rtl/gamepad_pmod_receiver_sync_edge_detect.sv
// Two-flop synchronizer for one asynchronous PMOD pin, followed by a history flop
// and a registered rising-edge detector.
module sync_edge_detect (
  input  logic clk,
  input  logic rst_n,
  input  logic pin_i,
  output logic sync_o,
  output logic rise_o
);

  logic meta_q;
  logic sync_q;
  logic hist_q;
  logic rise_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      hist_q <= 1'b0;
      rise_q <= 1'b0;
    end else begin
      meta_q <= pin_i;
      sync_q <= meta_q;
      hist_q <= sync_q;
      rise_q <= sync_q & ~hist_q;
    end
  end

  // Level taken from the history flop so it lines up with the registered rise pulse.
  assign sync_o = hist_q;
  assign rise_o = rise_q;

endmodule

// File: rtl/gamepad_pmod_receiver.sv
// Gamepad PMOD serial receiver: shifts the button stream in on pmod_clk, commits the
// selected controller's 12-bit word on pmod_latch, and drops presence on a frame timeout.
module gamepad_pmod_receiver
  import dino_pkg::*;
#(
  parameter int CONTROLLER_SEL = 0,
  parameter int FRAME_BITS     = 24,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              pmod_data,
  input  logic              pmod_clk,
  input  logic              pmod_latch,
  output logic              gamepad_is_present,
  output logic [BTN_W-1:0]  gamepad_buttons,
  output logic              gamepad_start,
  output logic              gamepad_up,
  output logic              gamepad_down,
  output logic              frame_valid,
  output logic              frame_error
);

  localparam int unsigned TW        = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TO_MAX  = TW'(TIMEOUT_CYCLES);
  localparam logic [4:0]  CNT_MAX   = '1;
  localparam logic [4:0]  FRAME_CNT = 5'(FRAME_BITS);

  logic data_sync, data_rise_unused;
  logic clk_sync_unused, clk_rise;
  logic latch_sync_unused, latch_rise;

  sync_edge_detect u_sync_data (
    .clk(clk), .rst_n(rst_n), .pin_i(pmod_data),
    .sync_o(data_sync), .rise_o(data_rise_unused)
  );
  sync_edge_detect u_sync_clk (
    .clk(clk), .rst_n(rst_n), .pin_i(pmod_clk),
    .sync_o(clk_sync_unused), .rise_o(clk_rise)
  );
  sync_edge_detect u_sync_latch (
    .clk(clk), .rst_n(rst_n), .pin_i(pmod_latch),
    .sync_o(latch_sync_unused), .rise_o(latch_rise)
  );

  logic [FRAME_BITS-1:0] shreg_q, shreg_d;
  logic [4:0]            bitcnt_q, bitcnt_d;
  logic [TW-1:0]         to_q, to_d;
  logic                  present_q, present_d;
  btn_word_t             buttons_q, buttons_d;
  logic                  valid_q, valid_d;
  logic                  error_q, error_d;
  btn_word_t             word;

  always_comb begin
    shreg_d   = shreg_q;
    bitcnt_d  = bitcnt_q;
    to_d      = to_q;
    present_d = present_q;
    buttons_d = buttons_q;
    valid_d   = 1'b0;
    error_d   = 1'b0;

    // Shift first so a latch in the same cycle sees the post-shift word and count.
    if (clk_rise) begin
      shreg_d  = {shreg_q[FRAME_BITS-2:0], data_sync};
      bitcnt_d = (bitcnt_q == CNT_MAX) ? CNT_MAX : bitcnt_q + 5'd1;
    end

    word = (CONTROLLER_SEL == 0) ? shreg_d[FRAME_BITS-1 -: BTN_W] : shreg_d[BTN_W-1:0];

    if (latch_rise) begin
      if (bitcnt_d == FRAME_CNT) begin
        valid_d = 1'b1;
        to_d    = '0;
        if (word == GAMEPAD_ABSENT_WORD) begin
          present_d = 1'b0;
          buttons_d = '0;
        end else begin
          present_d = 1'b1;
          buttons_d = word;
        end
      end else begin
        error_d = 1'b1;
      end
      bitcnt_d = '0;
    end

    if (!valid_d) begin
      if (to_q != TO_MAX) to_d = to_q + TW'(1);
      if (to_d == TO_MAX) begin
        present_d = 1'b0;
        buttons_d = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      shreg_q   <= '0;
      bitcnt_q  <= '0;
      to_q      <= '0;
      present_q <= 1'b0;
      buttons_q <= '0;
      valid_q   <= 1'b0;
      error_q   <= 1'b0;
    end else begin
      shreg_q   <= shreg_d;
      bitcnt_q  <= bitcnt_d;
      to_q      <= to_d;
      present_q <= present_d;
      buttons_q <= buttons_d;
      valid_q   <= valid_d;
      error_q   <= error_d;
    end
  end

  assign gamepad_is_present = present_q;
  assign gamepad_buttons    = buttons_q;
  assign gamepad_start      = buttons_q[BTN_START];
  assign gamepad_up         = buttons_q[BTN_UP];
  assign gamepad_down       = buttons_q[BTN_DOWN];
  assign frame_valid        = valid_q;
  assign frame_error        = error_q;

endmodule

// File: tb/tb_gamepad_pmod_receiver.sv
// Self-checking bench: two receivers (controller 1 and controller 2 selected) share one
// randomized PMOD stream and are compared every cycle against a frame-level model.
module tb_gamepad_pmod_receiver;

  localparam int TO = 100;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic pmod_data = 1'b0;
  logic pmod_clk = 1'b0;
  logic pmod_latch = 1'b0;

  logic        p0, s0, u0, d0, v0, e0;
  logic [11:0] b0;
  logic        p1, s1, u1, d1, v1, e1;
  logic [11:0] b1;

  always #5 clk = ~clk;

  gamepad_pmod_receiver #(.CONTROLLER_SEL(0), .FRAME_BITS(24), .TIMEOUT_CYCLES(TO)) dut0 (
    .clk(clk), .rst_n(rst_n), .pmod_data(pmod_data), .pmod_clk(pmod_clk),
    .pmod_latch(pmod_latch), .gamepad_is_present(p0), .gamepad_buttons(b0),
    .gamepad_start(s0), .gamepad_up(u0), .gamepad_down(d0),
    .frame_valid(v0), .frame_error(e0)
  );

  gamepad_pmod_receiver #(.CONTROLLER_SEL(1), .FRAME_BITS(24), .TIMEOUT_CYCLES(TO)) dut1 (
    .clk(clk), .rst_n(rst_n), .pmod_data(pmod_data), .pmod_clk(pmod_clk),
    .pmod_latch(pmod_latch), .gamepad_is_present(p1), .gamepad_buttons(b1),
    .gamepad_start(s1), .gamepad_up(u1), .gamepad_down(d1),
    .frame_valid(v1), .frame_error(e1)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Frame-level model. A pin level sampled at clock edge k becomes an event in the
  // receiver at edge k+3 (three clocks of synchronization and edge detection).
  logic [4:0]  hc, hl, hd;
  logic [23:0] msh;
  int          mcnt, mto;
  logic        mp0, mp1, mv, me;
  logic [11:0] mb0, mb1, w0, w1;
  bit          cr, lr, committed;
  bit          model_ok = 0;

  always @(posedge clk) begin
    if (!rst_n) begin
      hc = '0; hl = '0; hd = '0;
      msh = '0; mcnt = 0; mto = 0;
      mp0 = 0; mp1 = 0; mb0 = '0; mb1 = '0; mv = 0; me = 0;
      model_ok = 1;
    end else begin
      hc = {hc[3:0], pmod_clk};
      hl = {hl[3:0], pmod_latch};
      hd = {hd[3:0], pmod_data};
      cr = hc[3] && !hc[4];
      lr = hl[3] && !hl[4];
      mv = 0; me = 0; committed = 0;
      if (cr) begin
        msh = {msh[22:0], hd[3]};
        if (mcnt < 31) mcnt++;
      end
      if (lr) begin
        if (mcnt == 24) begin
          w0 = msh[23:12];
          w1 = msh[11:0];
          mp0 = (w0 != 12'hFFF); mb0 = mp0 ? w0 : 12'h000;
          mp1 = (w1 != 12'hFFF); mb1 = mp1 ? w1 : 12'h000;
          mv = 1; mto = 0; committed = 1;
        end else begin
          me = 1;
        end
        mcnt = 0;
      end
      if (!committed) begin
        if (mto < TO) mto++;
        if (mto == TO) begin
          mp0 = 0; mb0 = '0; mp1 = 0; mb1 = '0;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (model_ok) begin
      check("present0", p0, mp0);
      check("buttons0", b0, mb0);
      check("start0", s0, mb0[8]);
      check("up0", u0, mb0[7]);
      check("down0", d0, mb0[6]);
      check("valid0", v0, mv);
      check("error0", e0, me);
      check("present1", p1, mp1);
      check("buttons1", b1, mb1);
      check("start1", s1, mb1[8]);
      check("up1", u1, mb1[7]);
      check("down1", d1, mb1[6]);
      check("valid1", v1, mv);
      check("error1", e1, me);
    end
  end

  task automatic send_bits(input logic [25:0] pat, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      pmod_data = pat[i];
      repeat ($urandom_range(1, 2)) @(negedge clk);
      pmod_clk = 1'b1;
      repeat ($urandom_range(1, 2)) @(negedge clk);
      pmod_clk = 1'b0;
    end
  endtask

  // Raise latch and wait (bounded) for the chosen pulse on dut0: 0 = valid, 1 = error.
  task automatic latch_and_wait(input bit want_err, input string nm);
    int n;
    n = 0;
    @(negedge clk);
    pmod_latch = 1'b1;
    while (((want_err ? e0 : v0) !== 1'b1) && n < 40) begin
      @(negedge clk);
      n++;
    end
    check(nm, want_err ? e0 : v0, 1);
    pmod_latch = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    logic [25:0] pat;
    int nb;
    repeat (5) @(negedge clk);
    check("reset_present", p0, 0);
    check("reset_buttons", b0, 0);
    rst_n = 1'b1;

    // START+UP on controller 1, with exact latch-to-output latency.
    send_bits({2'b00, 12'h180, 12'h000}, 24);
    @(negedge clk);
    pmod_latch = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("latency3_valid", v0, 0);
    @(posedge clk);
    @(negedge clk);
    check("latency4_valid", v0, 1);
    check("t1_buttons", b0, 12'h180);
    check("t1_start", s0, 1);
    check("t1_up", u0, 1);
    check("t1_down", d0, 0);
    check("t1_present", p0, 1);
    @(negedge clk);
    check("t1_single_pulse", v0, 0);
    pmod_latch = 1'b0;
    repeat (2) @(negedge clk);

    // Controller 1 absent, controller 2 pressing DOWN.
    send_bits({2'b00, 12'hFFF, 12'h040}, 24);
    latch_and_wait(0, "t2_valid");
    check("t2_present0", p0, 0);
    check("t2_buttons0", b0, 0);
    check("t2_present1", p1, 1);
    check("t2_down1", d1, 1);
    check("t2_buttons1", b1, 12'h040);

    // Short and long frames, then a clean one.
    send_bits({2'b00, 12'h0F0, 12'h00F} >> 1, 23);
    latch_and_wait(1, "t3_err23");
    send_bits({1'b0, 12'h0F0, 12'h00F, 1'b1}, 25);
    latch_and_wait(1, "t3_err25");
    send_bits({2'b00, 12'h123, 12'h456}, 24);
    latch_and_wait(0, "t3_valid");
    check("t3_buttons0", b0, 12'h123);
    check("t3_buttons1", b1, 12'h456);

    // Timeout: commit edge C, still present at C+99, cleared at C+100.
    send_bits({2'b00, 12'h080, 12'h000}, 24);
    latch_and_wait(0, "t4_valid");
    repeat (97) @(posedge clk);
    @(negedge clk);
    check("t4_present_c99", p0, 1);
    check("t4_up_c99", u0, 1);
    @(posedge clk);
    @(negedge clk);
    check("t4_present_c100", p0, 0);
    check("t4_up_c100", u0, 0);
    send_bits({2'b00, 12'h080, 12'h000}, 24);
    latch_and_wait(0, "t4_revalid");
    check("t4_restored", p0, 1);
    check("t4_up_restored", u0, 1);

    // Latch and 24th pmod_clk rise in the same cycle.
    pat = {2'b00, 12'h200, 12'h001};
    send_bits(pat >> 1, 23);
    pmod_data = 1'b1;
    @(negedge clk);
    pmod_clk = 1'b1;
    pmod_latch = 1'b1;
    begin
      int n;
      n = 0;
      while (v0 !== 1'b1 && n < 40) begin
        @(negedge clk);
        n++;
      end
      check("t5_valid", v0, 1);
    end
    check("t5_buttons0", b0, 12'h200);
    check("t5_buttons1", b1, 12'h001);
    pmod_clk = 1'b0;
    pmod_latch = 1'b0;
    repeat (2) @(negedge clk);

    // Reset mid-frame.
    send_bits({2'b00, 12'hABC, 12'h123}, 10);
    pmod_data = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    check("t6_reset_present", p0, 0);
    check("t6_reset_buttons", b1, 0);
    send_bits({2'b00, 12'h000, 12'h3FF}, 14);
    latch_and_wait(1, "t6_error");
    check("t6_present0", p0, 0);
    check("t6_buttons0", b0, 0);
    check("t6_present1", p1, 0);
    check("t6_buttons1", b1, 0);

    // Randomized frames, lengths and idle gaps.
    for (int f = 0; f < 30; f++) begin
      nb = ($urandom_range(0, 2) == 0) ? $urandom_range(22, 26) : 24;
      pat = {$urandom} & 26'h3FFFFFF;
      if ($urandom_range(0, 4) == 0) pat[23:12] = 12'hFFF;
      if ($urandom_range(0, 4) == 0) pat[11:0] = 12'hFFF;
      send_bits(pat, nb);
      @(negedge clk);
      pmod_latch = 1'b1;
      repeat ($urandom_range(1, 5)) @(negedge clk);
      pmod_latch = 1'b0;
      repeat ($urandom_range(1, 6)) @(negedge clk);
      if ($urandom_range(0, 5) == 0) repeat ($urandom_range(20, 150)) @(negedge clk);
    end

    repeat (10) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
